// File: rtl/video_timing_gen_mp_if.sv
// Signal bundle for video_timing_gen_mp: runtime timing configuration and
// genlock controls in, sync/data-enable/coordinate timing out.
interface video_timing_gen_mp_if #(
    parameter int H_W = 12,
    parameter int V_W = 11,
    parameter int PPC = 1
);
    localparam int PXW = H_W + $clog2(PPC);

    logic           enable;
    logic [H_W-1:0] cfg_hlength, cfg_hsync_len, cfg_hbp_len, cfg_h_visible;
    logic [V_W-1:0] cfg_vlength, cfg_vsync_len, cfg_vbp_len, cfg_v_visible;
    logic           cfg_hsync_pol, cfg_vsync_pol;
    logic [H_W-1:0] cfg_sync_h_pos;
    logic [V_W-1:0] cfg_sync_v_pos;
    logic           cfg_update;
    logic           ext_sync_en, ext_sync;

    logic [H_W-1:0] timing_h_pos;
    logic [V_W-1:0] timing_v_pos;
    logic [PXW-1:0] pixel_x;
    logic [V_W-1:0] pixel_y;
    logic           video_hsync, video_vsync, video_den;
    logic           video_line_start, video_frame_start;
    logic [15:0]    frame_count;
    logic           locked, update_done;

    modport master (
        output enable, cfg_hlength, cfg_hsync_len, cfg_hbp_len, cfg_h_visible,
               cfg_vlength, cfg_vsync_len, cfg_vbp_len, cfg_v_visible,
               cfg_hsync_pol, cfg_vsync_pol, cfg_sync_h_pos, cfg_sync_v_pos,
               cfg_update, ext_sync_en, ext_sync,
        input  timing_h_pos, timing_v_pos, pixel_x, pixel_y, video_hsync, video_vsync,
               video_den, video_line_start, video_frame_start, frame_count, locked, update_done
    );

    modport slave (
        input  enable, cfg_hlength, cfg_hsync_len, cfg_hbp_len, cfg_h_visible,
               cfg_vlength, cfg_vsync_len, cfg_vbp_len, cfg_v_visible,
               cfg_hsync_pol, cfg_vsync_pol, cfg_sync_h_pos, cfg_sync_v_pos,
               cfg_update, ext_sync_en, ext_sync,
        output timing_h_pos, timing_v_pos, pixel_x, pixel_y, video_hsync, video_vsync,
               video_den, video_line_start, video_frame_start, frame_count, locked, update_done
    );
endinterface

// File: rtl/video_timing_gen_mp.sv
// Runtime-programmable multi-pixel video timing generator with frame-boundary
// shadow config, ext_sync genlock (jump on mismatch) and a natural-wrap frame counter.
module video_timing_gen_mp #(
    parameter int H_W        = 12,
    parameter int V_W        = 11,
    parameter int PPC        = 1,
    parameter int LOCK_COUNT = 3
) (
    input  logic                 pixel_clock,
    input  logic                 reset,
    video_timing_gen_mp_if.slave vif
);
    localparam int PXW = H_W + $clog2(PPC);
    localparam int SH  = $clog2(PPC);
    localparam int LCW = $clog2(LOCK_COUNT + 1);

    typedef struct packed {
        logic [H_W-1:0] hlen, hsync, hbp, hvis;
        logic [V_W-1:0] vlen, vsync, vbp, vvis;
        logic           hpol, vpol;
    } tcfg_t;

    tcfg_t          act_q, act_d, cfg_c;
    logic [H_W-1:0] h_q, h_d, h_inc, hvb, hve;
    logic [V_W-1:0] v_q, v_d, v_inc, vvb, vve;
    logic           pend_q, pend_d;
    logic [LCW-1:0] lock_q, lock_d;
    logic [15:0]    fc_q, fc_d;
    logic [2:0]     sync_q;
    logic           h_last, v_last, nat_wrap, edge_det, jump, load, hvis, vvis, den;

    logic [H_W-1:0] th_q;
    logic [V_W-1:0] tv_q, py_q;
    logic [PXW-1:0] px_q;
    logic           hs_q, vs_q, den_q, ls_q, fs_q, lk_q, ud_q;

    always_comb begin
        cfg_c.hlen  = vif.cfg_hlength;
        cfg_c.hsync = vif.cfg_hsync_len;
        cfg_c.hbp   = vif.cfg_hbp_len;
        cfg_c.hvis  = vif.cfg_h_visible;
        cfg_c.vlen  = vif.cfg_vlength;
        cfg_c.vsync = vif.cfg_vsync_len;
        cfg_c.vbp   = vif.cfg_vbp_len;
        cfg_c.vvis  = vif.cfg_v_visible;
        cfg_c.hpol  = vif.cfg_hsync_pol;
        cfg_c.vpol  = vif.cfg_vsync_pol;
    end

    assign hvb      = act_q.hsync + act_q.hbp;
    assign hve      = hvb + act_q.hvis - H_W'(1);
    assign vvb      = act_q.vsync + act_q.vbp;
    assign vve      = vvb + act_q.vvis - V_W'(1);
    assign h_last   = (h_q == act_q.hlen - H_W'(1));
    assign v_last   = (v_q == act_q.vlen - V_W'(1));
    assign nat_wrap = h_last & v_last;
    assign h_inc    = h_last ? '0 : h_q + H_W'(1);
    assign v_inc    = h_last ? (v_last ? '0 : v_q + V_W'(1)) : v_q;
    assign edge_det = sync_q[1] & ~sync_q[2];
    assign hvis     = (h_q >= hvb) && (h_q <= hve);
    assign vvis     = (v_q >= vvb) && (v_q <= vve);
    assign den      = hvis & vvis;

    always_comb begin
        h_d    = h_inc;
        v_d    = v_inc;
        act_d  = act_q;
        pend_d = pend_q;
        lock_d = lock_q;
        fc_d   = fc_q;
        jump   = 1'b0;
        load   = 1'b0;
        if (!vif.enable) begin
            h_d    = '0;
            v_d    = '0;
            act_d  = cfg_c;
            pend_d = 1'b0;
            lock_d = '0;
        end else begin
            // Genlock compares against where the counters would have gone anyway.
            if (edge_det && vif.ext_sync_en) begin
                if (h_inc == vif.cfg_sync_h_pos && v_inc == vif.cfg_sync_v_pos) begin
                    if (lock_q != LCW'(LOCK_COUNT)) lock_d = lock_q + LCW'(1);
                end else begin
                    jump   = 1'b1;
                    h_d    = vif.cfg_sync_h_pos;
                    v_d    = vif.cfg_sync_v_pos;
                    lock_d = '0;
                end
            end
            if (nat_wrap && !jump) begin
                fc_d = fc_q + 16'd1;
                if (pend_q || vif.cfg_update) begin
                    act_d  = cfg_c;
                    pend_d = 1'b0;
                    load   = 1'b1;
                end
            end else if (vif.cfg_update) begin
                pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            act_q  <= '0;
            h_q    <= '0;
            v_q    <= '0;
            pend_q <= 1'b0;
            lock_q <= '0;
            fc_q   <= '0;
            sync_q <= '0;
        end else begin
            act_q  <= act_d;
            h_q    <= h_d;
            v_q    <= v_d;
            pend_q <= pend_d;
            lock_q <= lock_d;
            fc_q   <= fc_d;
            sync_q <= {sync_q[1:0], vif.ext_sync};
        end
    end

    // Output stage: everything here reflects the counter state of the previous clock.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            th_q  <= '0;
            tv_q  <= '0;
            px_q  <= '0;
            py_q  <= '0;
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
            den_q <= 1'b0;
            ls_q  <= 1'b0;
            fs_q  <= 1'b0;
            lk_q  <= 1'b0;
            ud_q  <= 1'b0;
        end else begin
            th_q  <= vif.enable ? h_q : '0;
            tv_q  <= vif.enable ? v_q : '0;
            px_q  <= (vif.enable && den) ? (PXW'(h_q - hvb) << SH) : '0;
            py_q  <= (vif.enable && vvis) ? (v_q - vvb) : '0;
            hs_q  <= vif.enable ? ((h_q < act_q.hsync) ^ ~act_q.hpol) : ~vif.cfg_hsync_pol;
            vs_q  <= vif.enable ? ((v_q < act_q.vsync) ^ ~act_q.vpol) : ~vif.cfg_vsync_pol;
            den_q <= vif.enable & den;
            ls_q  <= vif.enable & vvis & (h_q == '0);
            fs_q  <= vif.enable & (h_q == '0) & (v_q == '0);
            lk_q  <= (lock_q == LCW'(LOCK_COUNT));
            ud_q  <= load;
        end
    end

    assign vif.timing_h_pos      = th_q;
    assign vif.timing_v_pos      = tv_q;
    assign vif.pixel_x           = px_q;
    assign vif.pixel_y           = py_q;
    assign vif.video_hsync       = hs_q;
    assign vif.video_vsync       = vs_q;
    assign vif.video_den         = den_q;
    assign vif.video_line_start  = ls_q;
    assign vif.video_frame_start = fs_q;
    assign vif.frame_count       = fc_q;
    assign vif.locked            = lk_q;
    assign vif.update_done       = ud_q;
endmodule

// File: tb/tb_video_timing_gen_mp.sv
// Bench for video_timing_gen_mp: linear-index frame model checked every cycle,
// plus directed frame-shape, shadow-update, genlock and reset scenarios.
module tb_video_timing_gen_mp;
    localparam int H_W = 12;
    localparam int V_W = 11;
    localparam int PPC = 2;
    localparam int LC  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    video_timing_gen_mp_if #(.H_W(H_W), .V_W(V_W), .PPC(PPC)) vif();

    video_timing_gen_mp #(.H_W(H_W), .V_W(V_W), .PPC(PPC), .LOCK_COUNT(LC)) dut (
        .pixel_clock(clk),
        .reset      (rst),
        .vif        (vif)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        int hl, hs, hb, hv, vl, vs, vb, vv;
        bit hp, vp;
    } mcfg_t;

    function automatic mcfg_t rd_cfg();
        mcfg_t c;
        c.hl = int'(vif.cfg_hlength);   c.hs = int'(vif.cfg_hsync_len);
        c.hb = int'(vif.cfg_hbp_len);   c.hv = int'(vif.cfg_h_visible);
        c.vl = int'(vif.cfg_vlength);   c.vs = int'(vif.cfg_vsync_len);
        c.vb = int'(vif.cfg_vbp_len);   c.vv = int'(vif.cfg_v_visible);
        c.hp = vif.cfg_hsync_pol;       c.vp = vif.cfg_vsync_pol;
        return c;
    endfunction

    // Model: position is one linear index into the frame; h/v are derived by div/mod.
    mcfg_t    act;
    int       m_idx, m_fc, m_lock;
    bit       m_pend;
    bit [2:0] m_ext;
    int e_h, e_v, e_px, e_py, e_hs, e_vs, e_den, e_ls, e_fs, e_fc, e_lk, e_ud;

    always @(posedge clk or posedge rst) begin : model
        int h, v, hvb, vvb, nxt, tgt, tot;
        bit hin, vin, edg, jump;
        if (rst) begin
            m_idx = 0; m_fc = 0; m_lock = 0; m_pend = 0; m_ext = '0;
            act = '{default: 0};
            e_h = 0; e_v = 0; e_px = 0; e_py = 0; e_hs = 0; e_vs = 0;
            e_den = 0; e_ls = 0; e_fs = 0; e_fc = 0; e_lk = 0; e_ud = 0;
        end else begin
            edg   = m_ext[1] && !m_ext[2];
            m_ext = {m_ext[1:0], vif.ext_sync};
            e_lk  = (m_lock == LC) ? 1 : 0;
            e_ud  = 0;
            if (!vif.enable) begin
                e_h = 0; e_v = 0; e_px = 0; e_py = 0; e_den = 0; e_ls = 0; e_fs = 0;
                e_hs = vif.cfg_hsync_pol ? 0 : 1;
                e_vs = vif.cfg_vsync_pol ? 0 : 1;
                act = rd_cfg(); m_idx = 0; m_pend = 0; m_lock = 0;
            end else begin
                h   = m_idx % act.hl;
                v   = m_idx / act.hl;
                hvb = act.hs + act.hb;
                vvb = act.vs + act.vb;
                hin = (h >= hvb) && (h < hvb + act.hv);
                vin = (v >= vvb) && (v < vvb + act.vv);
                e_h = h; e_v = v;
                e_den = (hin && vin) ? 1 : 0;
                e_px  = (hin && vin) ? (h - hvb) * PPC : 0;
                e_py  = vin ? v - vvb : 0;
                e_hs  = ((h < act.hs) == act.hp) ? 1 : 0;
                e_vs  = ((v < act.vs) == act.vp) ? 1 : 0;
                e_ls  = (vin && h == 0) ? 1 : 0;
                e_fs  = (m_idx == 0) ? 1 : 0;
                tot   = act.hl * act.vl;
                nxt   = (m_idx + 1) % tot;
                tgt   = int'(vif.cfg_sync_v_pos) * act.hl + int'(vif.cfg_sync_h_pos);
                jump  = 0;
                if (edg && vif.ext_sync_en) begin
                    if (nxt == tgt) m_lock = (m_lock < LC) ? m_lock + 1 : LC;
                    else begin jump = 1; m_lock = 0; end
                end
                if (m_idx == tot - 1 && !jump) begin
                    m_fc = (m_fc + 1) % 65536;
                    if (m_pend || vif.cfg_update) begin
                        act = rd_cfg(); m_pend = 0; e_ud = 1;
                    end
                end else if (vif.cfg_update) m_pend = 1;
                m_idx = jump ? tgt : nxt;
            end
            e_fc = m_fc;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("h_pos",       int'(vif.timing_h_pos),      e_h);
            check("v_pos",       int'(vif.timing_v_pos),      e_v);
            check("pixel_x",     int'(vif.pixel_x),           e_px);
            check("pixel_y",     int'(vif.pixel_y),           e_py);
            check("hsync",       int'(vif.video_hsync),       e_hs);
            check("vsync",       int'(vif.video_vsync),       e_vs);
            check("den",         int'(vif.video_den),         e_den);
            check("line_start",  int'(vif.video_line_start),  e_ls);
            check("frame_start", int'(vif.video_frame_start), e_fs);
            check("frame_count", int'(vif.frame_count),       e_fc);
            check("locked",      int'(vif.locked),            e_lk);
            check("update_done", int'(vif.update_done),       e_ud);
        end
    end

    // Called on a frame_start sample; runs to the next frame_start sample.
    // upd_at / ext_at are sample indices inside the frame at which to raise cfg_update / ext_sync.
    task automatic frame_stats(input int upd_at, input int ext_at, output int per, output int dn,
                               output int hs, output int vs, output int ud, output int pxm,
                               output int fcd);
        int fc0;
        per = 0; dn = 0; hs = 0; vs = 0; ud = 0; pxm = 0;
        fc0 = int'(vif.frame_count);
        do begin
            vif.cfg_update = (per == upd_at);
            if (per == ext_at) vif.ext_sync = 1'b1;
            else if (per == ext_at + 8) vif.ext_sync = 1'b0;
            dn += int'(vif.video_den);
            hs += int'(vif.video_hsync);
            vs += int'(vif.video_vsync);
            ud += int'(vif.update_done);
            if (vif.video_den && int'(vif.pixel_x) > pxm) pxm = int'(vif.pixel_x);
            @(posedge clk); #1;
            per++;
        end while (!vif.video_frame_start && per < 2000);
        vif.cfg_update = 1'b0;
        if (per >= 2000) check("frame_timeout", per, 0);
        fcd = (int'(vif.frame_count) - fc0 + 65536) % 65536;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int per, dn, hs, vs, ud, pxm, fcd, n;
        vif.enable = 1'b0;
        vif.cfg_hlength = 20; vif.cfg_hsync_len = 2; vif.cfg_hbp_len = 3; vif.cfg_h_visible = 10;
        vif.cfg_vlength = 8;  vif.cfg_vsync_len = 1; vif.cfg_vbp_len = 1; vif.cfg_v_visible = 4;
        vif.cfg_hsync_pol = 1'b1; vif.cfg_vsync_pol = 1'b1;
        vif.cfg_sync_h_pos = 7; vif.cfg_sync_v_pos = 3;
        vif.cfg_update = 1'b0; vif.ext_sync_en = 1'b0; vif.ext_sync = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_hsync", int'(vif.video_hsync), 0);
        check("idle_vsync", int'(vif.video_vsync), 0);
        check("idle_den",   int'(vif.video_den),   0);

        vif.enable = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!vif.video_den && n <= 300);
        check("den_first_latency", n, 46);

        n = 0;
        while (!vif.video_frame_start && n < 400) begin @(posedge clk); #1; n++; end
        frame_stats(-1, -1, per, dn, hs, vs, ud, pxm, fcd);
        check("frame_period", per, 160);
        check("den_per_frame", dn, 40);
        check("hsync_per_frame", hs, 16);
        check("vsync_per_frame", vs, 20);
        check("pixel_x_max_ppc2", pxm, 18);
        check("no_update_done", ud, 0);

        vif.cfg_hlength = 24;
        frame_stats(50, -1, per, dn, hs, vs, ud, pxm, fcd);
        check("shadow_cur_period", per, 160);
        check("shadow_update_done", ud, 1);
        frame_stats(-1, -1, per, dn, hs, vs, ud, pxm, fcd);
        check("shadow_new_period", per, 192);
        check("shadow_new_den", dn, 40);

        vif.cfg_hlength = 20;
        frame_stats(190, -1, per, dn, hs, vs, ud, pxm, fcd);
        check("wrap_update_period", per, 192);
        check("wrap_update_done", ud, 1);
        frame_stats(-1, -1, per, dn, hs, vs, ud, pxm, fcd);
        check("wrap_update_applied", per, 160);

        vif.ext_sync_en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            frame_stats(-1, 63, per, dn, hs, vs, ud, pxm, fcd);
            check("aligned_period", per, 160);
            check("lock_after_edge", int'(vif.locked), (i == 3) ? 1 : 0);
        end
        frame_stats(-1, 68, per, dn, hs, vs, ud, pxm, fcd);
        check("shifted_period", per, 165);
        check("lock_dropped", int'(vif.locked), 0);
        for (int i = 1; i <= 3; i++) begin
            frame_stats(-1, 63, per, dn, hs, vs, ud, pxm, fcd);
            check("relock_after_edge", int'(vif.locked), (i == 3) ? 1 : 0);
        end

        vif.cfg_hlength = 24;
        frame_stats(30, 156, per, dn, hs, vs, ud, pxm, fcd);
        check("wrap_jump_period", per, 253);
        check("wrap_jump_fc_delta", fcd, 1);
        check("wrap_jump_late_load", ud, 1);
        frame_stats(-1, -1, per, dn, hs, vs, ud, pxm, fcd);
        check("wrap_jump_new_period", per, 192);

        repeat (50) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("rst_h_pos",       int'(vif.timing_h_pos), 0);
        check("rst_den",         int'(vif.video_den),    0);
        check("rst_hsync",       int'(vif.video_hsync),  0);
        check("rst_frame_count", int'(vif.frame_count),  0);
        vif.enable = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_frame_count", int'(vif.frame_count), 0);
        check("post_rst_hsync",       int'(vif.video_hsync), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
